// File: rtl/controle_servo_multi_pkg.sv
// Shared timing defaults and elaboration-time helpers for the multi-channel servo controller.
package controle_servo_multi_pkg;

    localparam int PERIODO_PADRAO  = 1_000_000;
    localparam int LARG_MIN_PADRAO = 50_000;
    localparam int LARG_MAX_PADRAO = 100_000;
    localparam int PASSO_PADRAO    = 5_000;

    function automatic int largura_bits(input int valor);
        return (valor > 1) ? $clog2(valor) : 1;
    endfunction

    // Step between adjacent codes; code 1 maps to larg_min, so 2^pos_w-2 intervals remain.
    function automatic int calc_delta(input int larg_min, input int larg_max, input int pos_w);
        return (larg_max - larg_min) / ((1 << pos_w) - 2);
    endfunction

endpackage

// File: rtl/controle_servo_multi_canal_servo.sv
// One servo channel: code-to-width mapping, optional slew limit and the registered PWM compare.
module canal_servo
    import controle_servo_multi_pkg::*;
#(
    parameter int POS_W    = 3,
    parameter int W        = 20,
    parameter int LARG_MIN = LARG_MIN_PADRAO,
    parameter int DELTA    = 8_333,
    parameter int PASSO    = PASSO_PADRAO
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [W-1:0]     contador,
    input  logic             fim_periodo,
    input  logic [POS_W-1:0] codigo,
    input  logic             rampa_en,
    output logic             controle,
    output logic             db_estavel
);

    localparam logic [W-1:0] LARG_MIN_W = W'(LARG_MIN);
    localparam logic [W-1:0] DELTA_W    = W'(DELTA);
    localparam logic [W-1:0] PASSO_W    =
        (longint'(PASSO) >= (longint'(1) << W)) ? '1 : W'(PASSO);

    logic         habilitado, inicializado;
    logic [W-1:0] largura_atual;

    logic         habilitado_prox, inicializado_prox;
    logic [W-1:0] largura_prox, alvo, diferenca;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        habilitado_prox   = habilitado;
        inicializado_prox = inicializado;
        largura_prox      = largura_atual;
        diferenca         = '0;
        alvo              = LARG_MIN_W + (W'(codigo) - W'(1)) * DELTA_W;

        if (codigo == '0) begin
            habilitado_prox = 1'b0;
        end else begin
            habilitado_prox   = 1'b1;
            inicializado_prox = 1'b1;
            if (!inicializado || !rampa_en) begin
                largura_prox = alvo;
            end else if (alvo > largura_atual) begin
                diferenca    = alvo - largura_atual;
                largura_prox = largura_atual + ((diferenca > PASSO_W) ? PASSO_W : diferenca);
            end else begin
                diferenca    = largura_atual - alvo;
                largura_prox = largura_atual - ((diferenca > PASSO_W) ? PASSO_W : diferenca);
            end
        end
    end

    // NOTE: the async clear also forces controle low mid-pulse, without waiting for a clock edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            habilitado    <= 1'b0;
            inicializado  <= 1'b0;
            largura_atual <= '0;
            controle      <= 1'b0;
            db_estavel    <= 1'b0;
        end else begin
            controle <= habilitado && (contador < largura_atual);
            if (fim_periodo) begin
                habilitado    <= habilitado_prox;
                inicializado  <= inicializado_prox;
                largura_atual <= largura_prox;
                db_estavel    <= habilitado_prox && (largura_prox == alvo);
            end
        end
    end

endmodule

// File: rtl/controle_servo_multi.sv
// Multi-channel servo PWM: one shared period counter driving N_CH independent channels.
module controle_servo_multi
    import controle_servo_multi_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int POS_W    = 3,
    parameter int PERIODO  = PERIODO_PADRAO,
    parameter int LARG_MIN = LARG_MIN_PADRAO,
    parameter int LARG_MAX = LARG_MAX_PADRAO,
    parameter int PASSO    = PASSO_PADRAO
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_CH*POS_W-1:0]   posicao,
    input  logic                    rampa_en,
    output logic [N_CH-1:0]         controle,
    output logic [N_CH-1:0]         db_estavel,
    output logic                    fim_periodo
);

    localparam int           W      = largura_bits(PERIODO);
    localparam int           DELTA  = calc_delta(LARG_MIN, LARG_MAX, POS_W);
    localparam logic [W-1:0] ULTIMO = W'(PERIODO - 1);

    logic [W-1:0] contador;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contador <= '0;
        end else if (contador == ULTIMO) begin
            contador <= '0;
        end else begin
            contador <= contador + W'(1);
        end
    end

    assign fim_periodo = (contador == ULTIMO);

    for (genvar i = 0; i < N_CH; i++) begin : g_canal
        canal_servo #(
            .POS_W   (POS_W),
            .W       (W),
            .LARG_MIN(LARG_MIN),
            .DELTA   (DELTA),
            .PASSO   (PASSO)
        ) u_canal (
            .clock      (clock),
            .reset      (reset),
            .contador   (contador),
            .fim_periodo(fim_periodo),
            .codigo     (posicao[i*POS_W +: POS_W]),
            .rampa_en   (rampa_en),
            .controle   (controle[i]),
            .db_estavel (db_estavel[i])
        );
    end

endmodule

// File: tb/tb_controle_servo_multi.sv
// Self-checking bench: directed scenarios plus randomized periods against a behavioural model.
module tb_controle_servo_multi;

    localparam int N_CH     = 2;
    localparam int POS_W    = 3;
    localparam int PERIODO  = 1000;
    localparam int LARG_MIN = 50;
    localparam int LARG_MAX = 100;
    localparam int PASSO    = 10;
    localparam int DELTA    = (LARG_MAX - LARG_MIN) / (2 ** POS_W - 2);

    logic                  clock = 1'b0;
    logic                  reset;
    logic [N_CH*POS_W-1:0] posicao;
    logic                  rampa_en;
    logic [N_CH-1:0]       controle;
    logic [N_CH-1:0]       db_estavel;
    logic                  fim_periodo;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state, updated once per period boundary.
    bit m_hab [N_CH];
    bit m_ini [N_CH];
    int m_larg[N_CH];
    bit m_db  [N_CH];

    // Observations of the most recent period.
    int              medido[N_CH];
    logic [N_CH-1:0] db_obs;

    controle_servo_multi #(
        .N_CH(N_CH), .POS_W(POS_W), .PERIODO(PERIODO),
        .LARG_MIN(LARG_MIN), .LARG_MAX(LARG_MAX), .PASSO(PASSO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .posicao    (posicao),
        .rampa_en   (rampa_en),
        .controle   (controle),
        .db_estavel (db_estavel),
        .fim_periodo(fim_periodo)
    );

    always #5 clock = ~clock;

    function automatic logic [N_CH*POS_W-1:0] cod(input int c1, input int c0);
        logic [N_CH*POS_W-1:0] v;
        v = '0;
        v[0 +: POS_W]     = POS_W'(c0);
        v[POS_W +: POS_W] = POS_W'(c1);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_hab[i] = 0; m_ini[i] = 0; m_larg[i] = 0; m_db[i] = 0;
        end
    endtask

    task automatic model_boundary(input logic [N_CH*POS_W-1:0] pos, input logic rampa);
        for (int i = 0; i < N_CH; i++) begin
            int code;
            int alvo;
            code = int'(pos[i*POS_W +: POS_W]);
            if (code == 0) begin
                m_hab[i] = 0;
                m_db[i]  = 0;
            end else begin
                alvo = LARG_MIN + (code - 1) * DELTA;
                if (!m_ini[i] || !rampa)
                    m_larg[i] = alvo;
                else if (m_larg[i] < alvo)
                    m_larg[i] = (alvo - m_larg[i] > PASSO) ? m_larg[i] + PASSO : alvo;
                else
                    m_larg[i] = (m_larg[i] - alvo > PASSO) ? m_larg[i] - PASSO : alvo;
                m_ini[i] = 1;
                m_hab[i] = 1;
                m_db[i]  = (m_larg[i] == alvo);
            end
        end
    endtask

    // Runs one counter-aligned period, checking every cycle against the model.
    // posicao/rampa_en take their final value at cycle t_change; earlier in the
    // period they hold the inverted value so that non-boundary sampling would show.
    task automatic step_period(input logic [N_CH*POS_W-1:0] pos, input logic rampa,
                               input int t_change, input string tag);
        int              exp_w[N_CH];
        int              bad_shape[N_CH];
        int              bad_fim;
        int              bad_db;
        logic [N_CH-1:0] exp_db;
        for (int i = 0; i < N_CH; i++) begin
            exp_w[i]     = m_hab[i] ? m_larg[i] : 0;
            exp_db[i]    = m_db[i];
            medido[i]    = 0;
            bad_shape[i] = 0;
        end
        bad_fim = 0;
        bad_db  = 0;
        for (int c = 0; c < PERIODO; c++) begin
            @(negedge clock);
            if (fim_periodo !== (c == PERIODO - 1)) bad_fim++;
            if (db_estavel !== exp_db) bad_db++;
            if (c == PERIODO / 2) db_obs = db_estavel;
            for (int i = 0; i < N_CH; i++) begin
                logic exp_bit;
                exp_bit = (c >= 1) && (c - 1 < exp_w[i]);
                if (controle[i] === 1'b1) medido[i]++;
                if (controle[i] !== exp_bit) bad_shape[i]++;
            end
            if (c == 0 && t_change > 0) begin
                posicao  = ~pos;
                rampa_en = ~rampa;
            end
            if (c == t_change) begin
                posicao  = pos;
                rampa_en = rampa;
            end
        end
        n_tests++;
        if (bad_fim != 0) begin
            n_fail++;
            $display("FAIL %s fim_periodo: %0d wrong cycles, required 0", tag, bad_fim);
        end
        n_tests++;
        if (bad_db != 0) begin
            n_fail++;
            $display("FAIL %s db_estavel: %0d cycles differ, got %b required %b", tag, bad_db, db_obs, exp_db);
        end
        for (int i = 0; i < N_CH; i++) begin
            n_tests++;
            if (medido[i] != exp_w[i] || bad_shape[i] != 0) begin
                n_fail++;
                $display("FAIL %s ch%0d width: got %0d (%0d misplaced cycles) required %0d",
                         tag, i, medido[i], bad_shape[i], exp_w[i]);
            end
        end
        model_boundary(pos, rampa);
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        posicao  = '0;
        rampa_en = 1'b0;
        model_reset();
        #22;
        n_tests++;
        if (controle !== '0 || db_estavel !== '0 || fim_periodo !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: controle=%b db=%b fim=%b required 00 00 0",
                     controle, db_estavel, fim_periodo);
        end
        @(posedge clock);
        #1 reset = 1'b1;
        for (int p = 0; p < 3; p++) step_period(cod(0, 0), 1'b0, 0, "reset_idle");
    endtask

    task automatic test_first_enable();
        step_period(cod(0, 1), 1'b1, 0, "first_enable_a");
        step_period(cod(0, 1), 1'b1, 0, "first_enable_b");
        n_tests++;
        if (medido[0] != 50 || medido[1] != 0 || db_obs !== 2'b01) begin
            n_fail++;
            $display("FAIL first_enable: got %0d/%0d db=%b required 50/0 db=01",
                     medido[0], medido[1], db_obs);
        end
    endtask

    task automatic test_ramp_up();
        int              larg_esp[5] = '{60, 70, 80, 90, 98};
        logic [N_CH-1:0] db_esp[5]   = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
        step_period(cod(0, 7), 1'b1, 0, "ramp_start");
        for (int k = 0; k < 5; k++) begin
            step_period(cod(0, 7), 1'b1, 0, "ramp_step");
            n_tests++;
            if (medido[0] != larg_esp[k] || db_obs !== db_esp[k]) begin
                n_fail++;
                $display("FAIL ramp_up step %0d: got %0d db=%b required %0d db=%b",
                         k, medido[0], db_obs, larg_esp[k], db_esp[k]);
            end
        end
    endtask

    task automatic test_immediate_simultaneous();
        step_period(cod(4, 1), 1'b0, 0, "immediate_a");
        step_period(cod(4, 1), 1'b0, 0, "immediate_b");
        n_tests++;
        if (medido[0] != 50 || medido[1] != 74 || db_obs !== 2'b11) begin
            n_fail++;
            $display("FAIL immediate_simultaneous: got %0d/%0d db=%b required 50/74 db=11",
                     medido[0], medido[1], db_obs);
        end
    endtask

    task automatic test_disable_midpulse();
        int larg_esp[3] = '{60, 70, 74};
        step_period(cod(4, 0), 1'b1, 20, "disable_mid");
        n_tests++;
        if (medido[0] != 50) begin
            n_fail++;
            $display("FAIL disable_midpulse current: got %0d required 50", medido[0]);
        end
        step_period(cod(4, 4), 1'b1, 0, "disabled");
        n_tests++;
        if (medido[0] != 0 || db_obs !== 2'b10) begin
            n_fail++;
            $display("FAIL disabled_period: got %0d db=%b required 0 db=10", medido[0], db_obs);
        end
        for (int k = 0; k < 3; k++) begin
            step_period(cod(4, 4), 1'b1, 0, "reenable");
            n_tests++;
            if (medido[0] != larg_esp[k]) begin
                n_fail++;
                $display("FAIL reenable step %0d: got %0d required %0d", k, medido[0], larg_esp[k]);
            end
        end
    endtask

    task automatic test_reset_midpulse();
        for (int c = 0; c <= 20; c++) @(negedge clock);
        n_tests++;
        if (controle !== 2'b11) begin
            n_fail++;
            $display("FAIL pulse_before_reset: got %b required 11", controle);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (controle !== 2'b00 || db_estavel !== 2'b00 || fim_periodo !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midpulse: controle=%b db=%b fim=%b required 00 00 0",
                     controle, db_estavel, fim_periodo);
        end
        model_reset();
        @(posedge clock);
        #1 reset = 1'b1;
        step_period(cod(0, 7), 1'b1, 0, "post_reset_empty");
        n_tests++;
        if (medido[0] != 0 || medido[1] != 0) begin
            n_fail++;
            $display("FAIL post_reset_empty: got %0d/%0d required 0/0", medido[0], medido[1]);
        end
        step_period(cod(0, 7), 1'b1, 0, "post_reset_jump");
        n_tests++;
        if (medido[0] != 98 || db_obs !== 2'b01) begin
            n_fail++;
            $display("FAIL post_reset_jump: got %0d db=%b required 98 db=01", medido[0], db_obs);
        end
    endtask

    task automatic test_random();
        for (int p = 0; p < 20; p++) begin
            logic [N_CH*POS_W-1:0] pos;
            logic                  rampa;
            pos   = (N_CH*POS_W)'($urandom);
            rampa = ($urandom_range(0, 3) != 0);
            step_period(pos, rampa, int'($urandom_range(1, PERIODO - 1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_first_enable();
        test_ramp_up();
        test_immediate_simultaneous();
        test_disable_midpulse();
        test_reset_midpulse();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
